asteroid_sized: RTL and testbench
=================================

ASTEROID_SIZED -- requirements
Module: asteroid_sized

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  RADIUS, 1, half-size in pixels; body is (2*RADIUS+1) square; legal range 1..7.
  XLOC_START, 320, reset/respawn x-centre.
  YLOC_START, 240, reset/respawn y-centre.
  XDIR_START, 0, reset x-direction (0=left, 1=right).
  YDIR_START, 0, reset y-direction (0=up, 1=down).
  EXPLODE_MOVES, 8, move strobes spent in EXPLODE.
  RESPAWN_MOVES, 64, move strobes spent in DEAD before respawn.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  100 MHz system clock.
  rst  input  1  reset.
  pixpulse  input  1  25 MHz pixel enable, 1 cycle in 4.
  hcount  input  10  current x (0=left).
  vcount  input  10  current y (0=top).
  empty  input  1  current pixel unoccupied.
  move  input  1  position-update strobe, once per frame.
  hit  input  1  shot/ship contact on this asteroid.
  draw_asteroid  output  1  current pixel belongs to body.
  alive  output  1  state is ALIVE.
  destroyed  output  1  one-clk pulse on ALIVE->EXPLODE.
  xloc  output  10  centre x.
  yloc  output  10  centre y.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and rst.

Function
REQ-004 All state SHALL change only on clk edges with pixpulse=1, except destroyed, which is a single-clk pulse on that same edge.
REQ-005 The neighbour ring SHALL be the four side vectors lft/rgt/top/bot, each N=2*RADIUS+3 bits, cleared on the pixpulse edge following a move update.
REQ-006 With empty=0: rgt[k] (lft[k]) SHALL set when hcount==xloc+RADIUS+1 (hcount+RADIUS+1==xloc) and vcount+k==yloc+RADIUS+1; bot[k] (top[k]) SHALL set when vcount==yloc+RADIUS+1 (vcount+RADIUS+1==yloc) and hcount+k==xloc+RADIUS+1; comparisons SHALL be 11-bit so no underflow wraps.
REQ-007 Blocked terms: side_up/side_lft = OR of bits [RADIUS+1 .. 2*RADIUS+1]; side_dn/side_rgt = OR of bits [1 .. RADIUS+1].
REQ-008 Corner terms: corner_lft_up = lft[N-1] & ~top_lft & ~lft_up; corner_rgt_up = rgt[N-1] & ~top_rgt & ~rgt_up; corner_lft_dn = lft[0] & ~bot_lft & ~lft_dn; corner_rgt_dn = rgt[0] & ~bot_rgt & ~rgt_dn.
REQ-009 In ALIVE, on move: per axis, if the heading-side blocked term or matching corner is set, the axis SHALL step 1 pixel opposite and its direction bit SHALL invert; otherwise step 1 pixel in heading; both axes evaluated independently in the same update.
REQ-010 draw_asteroid SHALL be 1 in ALIVE when |hcount-xloc|<=RADIUS and |vcount-yloc|<=RADIUS; in EXPLODE only when additionally hcount[0]^vcount[0]^explode_cnt[0]=1; 0 in DEAD.
REQ-011 FSM states ALIVE, EXPLODE, DEAD. ALIVE->EXPLODE on hit; EXPLODE->DEAD after EXPLODE_MOVES moves; DEAD->ALIVE after RESPAWN_MOVES moves.
REQ-012 On respawn, xloc/yloc SHALL reload start values, xdir/ydir SHALL both invert versus their values at the hit, and the ring SHALL clear.
REQ-013 hit outside ALIVE SHALL be ignored; hit and move together in ALIVE: hit wins, no position update.
REQ-014 Position SHALL freeze in EXPLODE and DEAD; ring capture SHALL be suppressed outside ALIVE.
REQ-015 alive SHALL equal (state==ALIVE) combinationally from the state register.

Reset
REQ-016 rst=1 SHALL immediately force ALIVE, xloc=XLOC_START, yloc=YLOC_START, xdir=XDIR_START, ydir=YDIR_START, all ring bits 0, counters 0, destroyed=0, irrespective of pixpulse or mid-explosion state.

Structure
REQ-017 State encoding and screen constants (640x480) SHALL live in shared include asteroid_defs.
REQ-018 Ring capture plus blocked/corner decode SHALL be sub-module asteroid_ring_scan, parameterised by RADIUS.

Verification
REQ-019 RADIUS=3, start (320,240), dir 00, wall column at x=310 -> after moves xloc decrements to 314, next move xloc=315, xdir=1, yloc keeps decrementing.
REQ-020 RADIUS=1, single occupied pixel at (318,238) only (dir 00) -> corner_lft_up: both axes reverse, (320,240)->(321,241).
REQ-021 hit with move same pixpulse -> destroyed pulses 1 clk, alive=0, position frozen, 8 moves later body undrawn, 64 moves later alive=1 at start, dirs inverted.
REQ-022 hit during EXPLODE or DEAD -> no destroyed pulse, counters unaffected.
REQ-023 rst asserted mid-EXPLODE without pixpulse -> same clk: alive=1, xloc/yloc = start.
REQ-024 xloc=2 with RADIUS=3 scanning hcount=0..9 -> no lft bit set, no spurious wrap hit.

Source files
------------

// File: rtl/asteroid_defs.sv
// -----------------------------------------------------------------------------
// asteroid_defs
// Shared definitions for the asteroid block:
//   - screen geometry (640x480) used for the default spawn point
//   - coordinate types: 10-bit screen coordinates and 11-bit comparison
//     values, so that "x - something" never wraps around
//   - FSM state encoding
//   - decoded neighbour-ring flags passed from the ring scanner to the top
// -----------------------------------------------------------------------------
package asteroid_defs;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int CMP_W    = COORD_W + 1;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CMP_W-1:0]   cmp_t;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_EXPLODE = 2'd1,
        ST_DEAD    = 2'd2
    } ast_state_t;

    // Blocked and corner terms decoded from the four side vectors.
    typedef struct packed {
        logic lft_up;
        logic lft_dn;
        logic rgt_up;
        logic rgt_dn;
        logic top_lft;
        logic top_rgt;
        logic bot_lft;
        logic bot_rgt;
        logic corner_lft_up;
        logic corner_rgt_up;
        logic corner_lft_dn;
        logic corner_rgt_dn;
    } ring_dec_t;

    // Zero-extend a screen coordinate so sums stay exact in comparisons.
    function automatic cmp_t widen(input coord_t c);
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/asteroid_ring_scan.sv
// -----------------------------------------------------------------------------
// asteroid_ring_scan
// Captures the occupied pixels in the one-pixel ring surrounding the asteroid
// body while the raster scans past, and decodes them into blocked/corner terms.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   i_pixpulse    : pixel enable; the ring only changes on enabled edges
//   i_capture     : current pixel is occupied and capture is allowed
//   i_clear       : wipe the ring on this enabled edge (wins over capture)
//   i_hcount/i_vcount : current raster position
//   i_xloc/i_yloc : asteroid centre
//   o_dec         : decoded blocked/corner flags
//
// Bit k of each side vector: lft/rgt bit k sits at row yloc+RADIUS+1-k (high
// bits are up); top/bot bit k sits at column xloc+RADIUS+1-k (high bits are
// left). Bits 0 and N-1 are the diagonal corner pixels.
// -----------------------------------------------------------------------------
module asteroid_ring_scan
    import asteroid_defs::*;
#(
    parameter int RADIUS = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_pixpulse,
    input  logic      i_capture,
    input  logic      i_clear,
    input  coord_t    i_hcount,
    input  coord_t    i_vcount,
    input  coord_t    i_xloc,
    input  coord_t    i_yloc,
    output ring_dec_t o_dec
);

    localparam int   N  = 2 * RADIUS + 3;
    localparam int   HI = 2 * RADIUS + 1;
    localparam cmp_t R1 = cmp_t'(RADIUS + 1);

    logic [N-1:0] r_lft;
    logic [N-1:0] r_rgt;
    logic [N-1:0] r_top;
    logic [N-1:0] r_bot;

    logic [N-1:0] w_lft_set;
    logic [N-1:0] w_rgt_set;
    logic [N-1:0] w_top_set;
    logic [N-1:0] w_bot_set;

    cmp_t w_h;
    cmp_t w_v;
    cmp_t w_x;
    cmp_t w_y;

    assign w_h = widen(i_hcount);
    assign w_v = widen(i_vcount);
    assign w_x = widen(i_xloc);
    assign w_y = widen(i_yloc);

    // Terms are moved to the addition side so no subtraction can underflow.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_lft_set = '0;
        w_rgt_set = '0;
        w_top_set = '0;
        w_bot_set = '0;
        for (int k = 0; k < N; k++) begin
            w_rgt_set[k] = (w_h == w_x + R1) && (w_v + cmp_t'(k) == w_y + R1);
            w_lft_set[k] = (w_h + R1 == w_x) && (w_v + cmp_t'(k) == w_y + R1);
            w_bot_set[k] = (w_v == w_y + R1) && (w_h + cmp_t'(k) == w_x + R1);
            w_top_set[k] = (w_v + R1 == w_y) && (w_h + cmp_t'(k) == w_x + R1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state, so
            // every register samples pre-edge values regardless of order.
            r_lft <= '0;
            r_rgt <= '0;
            r_top <= '0;
            r_bot <= '0;
        end else if (i_pixpulse) begin
            if (i_clear) begin
                r_lft <= '0;
                r_rgt <= '0;
                r_top <= '0;
                r_bot <= '0;
            end else if (i_capture) begin
                r_lft <= r_lft | w_lft_set;
                r_rgt <= r_rgt | w_rgt_set;
                r_top <= r_top | w_top_set;
                r_bot <= r_bot | w_bot_set;
            end
        end
    end

    // Upper/left half terms include the centre bit, as do lower/right halves.
    always_comb begin
        o_dec         = '0;
        o_dec.lft_up  = |r_lft[HI -: RADIUS + 1];
        o_dec.lft_dn  = |r_lft[RADIUS + 1 -: RADIUS + 1];
        o_dec.rgt_up  = |r_rgt[HI -: RADIUS + 1];
        o_dec.rgt_dn  = |r_rgt[RADIUS + 1 -: RADIUS + 1];
        o_dec.top_lft = |r_top[HI -: RADIUS + 1];
        o_dec.top_rgt = |r_top[RADIUS + 1 -: RADIUS + 1];
        o_dec.bot_lft = |r_bot[HI -: RADIUS + 1];
        o_dec.bot_rgt = |r_bot[RADIUS + 1 -: RADIUS + 1];

        // A diagonal pixel only counts when neither adjoining side saw it.
        o_dec.corner_lft_up = r_lft[N-1] & ~o_dec.top_lft & ~o_dec.lft_up;
        o_dec.corner_rgt_up = r_rgt[N-1] & ~o_dec.top_rgt & ~o_dec.rgt_up;
        o_dec.corner_lft_dn = r_lft[0]   & ~o_dec.bot_lft & ~o_dec.lft_dn;
        o_dec.corner_rgt_dn = r_rgt[0]   & ~o_dec.bot_rgt & ~o_dec.rgt_dn;
    end

endmodule

// File: rtl/asteroid_sized.sv
// -----------------------------------------------------------------------------
// asteroid_sized
// A square asteroid of (2*RADIUS+1) pixels that drifts diagonally one pixel
// per frame, bounces off anything occupying its surrounding ring, and on a hit
// explodes (checkerboard flicker), disappears, then respawns at its start
// point with both directions reversed.
//
// Ports
//   clk, rst        : 100 MHz clock, asynchronous active-high reset
//   pixpulse        : 25 MHz pixel enable; all state moves only on it
//   hcount, vcount  : current raster position
//   empty           : current pixel is unoccupied
//   move            : once-per-frame position update strobe
//   hit             : contact on this asteroid
//   draw_asteroid   : current pixel belongs to the body
//   alive           : FSM is in ALIVE
//   destroyed       : one-clk pulse on the ALIVE->EXPLODE edge
//   xloc, yloc      : body centre
// -----------------------------------------------------------------------------
module asteroid_sized
    import asteroid_defs::*;
#(
    parameter int RADIUS        = 1,
    parameter int XLOC_START    = SCREEN_W / 2,
    parameter int YLOC_START    = SCREEN_H / 2,
    parameter bit XDIR_START    = 1'b0,
    parameter bit YDIR_START    = 1'b0,
    parameter int EXPLODE_MOVES = 8,
    parameter int RESPAWN_MOVES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       empty,
    input  logic       move,
    input  logic       hit,
    output logic       draw_asteroid,
    output logic       alive,
    output logic       destroyed,
    output logic [9:0] xloc,
    output logic [9:0] yloc
);

    localparam int CNT_MAX = (EXPLODE_MOVES > RESPAWN_MOVES) ? EXPLODE_MOVES : RESPAWN_MOVES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] EXPLODE_LAST = CNT_W'(EXPLODE_MOVES - 1);
    localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_MOVES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam cmp_t             RAD          = cmp_t'(RADIUS);

    ast_state_t       r_state;
    coord_t           r_xloc;
    coord_t           r_yloc;
    logic             r_xdir;      // 1 = right
    logic             r_ydir;      // 1 = down
    logic [CNT_W-1:0] r_cnt;       // moves spent in EXPLODE or DEAD
    logic             r_destroyed;
    logic             r_clear;     // ring wipe owed after a position update

    ring_dec_t w_dec;
    logic      w_capture;
    logic      w_respawn;
    logic      w_ring_clear;
    logic      w_corner;
    logic      w_bounce_x;
    logic      w_bounce_y;
    logic      w_step_right;
    logic      w_step_down;
    coord_t    w_x_next;
    coord_t    w_y_next;
    logic      w_in_box;
    logic      w_draw;
    cmp_t      w_h;
    cmp_t      w_v;
    cmp_t      w_x;
    cmp_t      w_y;

    assign w_capture    = (r_state == ST_ALIVE) && !empty;
    assign w_respawn    = pixpulse && move && (r_state == ST_DEAD) && (r_cnt == RESPAWN_LAST);
    assign w_ring_clear = r_clear | w_respawn;

    asteroid_ring_scan #(
        .RADIUS(RADIUS)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_pixpulse(pixpulse),
        .i_capture (w_capture),
        .i_clear   (w_ring_clear),
        .i_hcount  (hcount),
        .i_vcount  (vcount),
        .i_xloc    (r_xloc),
        .i_yloc    (r_yloc),
        .o_dec     (w_dec)
    );

    // Bounce decision: a blocked heading side or the corner on the diagonal
    // of travel reverses that axis; the corner reverses both.
    always_comb begin
        w_corner = 1'b0;
        unique case ({r_xdir, r_ydir})
            2'b00:   w_corner = w_dec.corner_lft_up;
            2'b10:   w_corner = w_dec.corner_rgt_up;
            2'b01:   w_corner = w_dec.corner_lft_dn;
            default: w_corner = w_dec.corner_rgt_dn;
        endcase

        w_bounce_x = (r_xdir ? (w_dec.rgt_up | w_dec.rgt_dn)
                             : (w_dec.lft_up | w_dec.lft_dn)) | w_corner;
        w_bounce_y = (r_ydir ? (w_dec.bot_lft | w_dec.bot_rgt)
                             : (w_dec.top_lft | w_dec.top_rgt)) | w_corner;

        w_step_right = r_xdir ^ w_bounce_x;
        w_step_down  = r_ydir ^ w_bounce_y;
        w_x_next     = w_step_right ? r_xloc + 10'd1 : r_xloc - 10'd1;
        w_y_next     = w_step_down  ? r_yloc + 10'd1 : r_yloc - 10'd1;
    end

    // Body test in 11 bits: |h-x| <= R  <=>  h+R >= x  and  h <= x+R.
    assign w_h = widen(hcount);
    assign w_v = widen(vcount);
    assign w_x = widen(r_xloc);
    assign w_y = widen(r_yloc);

    always_comb begin
        w_in_box = (w_h + RAD >= w_x) && (w_h <= w_x + RAD) &&
                   (w_v + RAD >= w_y) && (w_v <= w_y + RAD);
        w_draw   = 1'b0;
        unique case (r_state)
            ST_ALIVE:   w_draw = w_in_box;
            ST_EXPLODE: w_draw = w_in_box & (hcount[0] ^ vcount[0] ^ r_cnt[0]);
            default:    w_draw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ALIVE;
            r_xloc      <= coord_t'(XLOC_START);
            r_yloc      <= coord_t'(YLOC_START);
            r_xdir      <= XDIR_START;
            r_ydir      <= YDIR_START;
            r_cnt       <= '0;
            r_destroyed <= 1'b0;
            r_clear     <= 1'b0;
        end else begin
            // destroyed runs every clk so it stays high for exactly one clk.
            r_destroyed <= 1'b0;
            if (pixpulse) begin
                r_clear <= 1'b0;
                unique case (r_state)
                    ST_ALIVE: begin
                        // hit takes priority: no position update that frame.
                        if (hit) begin
                            r_state     <= ST_EXPLODE;
                            r_cnt       <= '0;
                            r_destroyed <= 1'b1;
                        end else if (move) begin
                            r_xloc  <= w_x_next;
                            r_yloc  <= w_y_next;
                            r_xdir  <= r_xdir ^ w_bounce_x;
                            r_ydir  <= r_ydir ^ w_bounce_y;
                            r_clear <= 1'b1;
                        end
                    end
                    ST_EXPLODE: begin
                        if (move) begin
                            if (r_cnt == EXPLODE_LAST) begin
                                r_state <= ST_DEAD;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (move) begin
                            if (r_cnt == RESPAWN_LAST) begin
                                // Directions were frozen since the hit, so
                                // inverting now reverses the pre-hit heading.
                                r_state <= ST_ALIVE;
                                r_cnt   <= '0;
                                r_xloc  <= coord_t'(XLOC_START);
                                r_yloc  <= coord_t'(YLOC_START);
                                r_xdir  <= ~r_xdir;
                                r_ydir  <= ~r_ydir;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: r_state <= ST_ALIVE;
                endcase
            end
        end
    end

    assign alive         = (r_state == ST_ALIVE);
    assign destroyed     = r_destroyed;
    assign xloc          = r_xloc;
    assign yloc          = r_yloc;
    assign draw_asteroid = w_draw;

endmodule

// File: tb/tb_asteroid_sized.sv
// -----------------------------------------------------------------------------
// tb_asteroid_sized
// Three instances share all inputs: dut_a (RADIUS=3), dut_b (RADIUS=1) and
// dut_c (RADIUS=3, spawned at x=2 next to the left screen edge). Each scenario
// resets everything and then checks only the instance it targets. The raster
// is driven only over the ring window of interest, pixel by pixel.
// -----------------------------------------------------------------------------
module tb_asteroid_sized;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount   = '0;
    logic [9:0] vcount   = '0;
    logic       empty    = 1'b1;
    logic       move     = 1'b0;
    logic       hit      = 1'b0;

    logic       a_draw, a_alive, a_destroyed;
    logic [9:0] a_xloc, a_yloc;
    logic       b_draw, b_alive, b_destroyed;
    logic [9:0] b_xloc, b_yloc;
    logic       c_draw, c_alive, c_destroyed;
    logic [9:0] c_xloc, c_yloc;

    int n_checks  = 0;
    int n_pass    = 0;
    int wall_x    = -1;
    int obs_x     = -1;
    int obs_y     = -1;
    int d_cycles  = 0;

    asteroid_sized #(.RADIUS(3)) dut_a (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .empty(empty), .move(move), .hit(hit), .draw_asteroid(a_draw),
        .alive(a_alive), .destroyed(a_destroyed), .xloc(a_xloc), .yloc(a_yloc)
    );

    asteroid_sized #(.RADIUS(1)) dut_b (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .empty(empty), .move(move), .hit(hit), .draw_asteroid(b_draw),
        .alive(b_alive), .destroyed(b_destroyed), .xloc(b_xloc), .yloc(b_yloc)
    );

    asteroid_sized #(.RADIUS(3), .XLOC_START(2)) dut_c (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .empty(empty), .move(move), .hit(hit), .draw_asteroid(c_draw),
        .alive(c_alive), .destroyed(c_destroyed), .xloc(c_xloc), .yloc(c_yloc)
    );

    always #5 clk = ~clk;

    // Clock cycles during which dut_a holds destroyed high.
    always @(negedge clk) begin
        if (a_destroyed === 1'b1) d_cycles++;
    end

    typedef struct {
        int   h;
        int   v;
        logic exp_a;
        logic exp_b;
        logic exp_c;
    } draw_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One pixel on one pixpulse, then three idle clocks (1-in-4 enable).
    task automatic pix(input int h, input int v, input logic e, input logic mv, input logic ht);
        @(negedge clk);
        hcount   = 10'(h);
        vcount   = 10'(v);
        empty    = e;
        move     = mv;
        hit      = ht;
        pixpulse = 1'b1;
        @(negedge clk);
        pixpulse = 1'b0;
        move     = 1'b0;
        hit      = 1'b0;
        empty    = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_moves(input int n);
        repeat (n) pix(0, 0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic peek(input int h, input int v);
        @(negedge clk);
        hcount = 10'(h);
        vcount = 10'(v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic occupied(input int h, input int v);
        return (h == wall_x) || (h == obs_x && v == obs_y);
    endfunction

    // Scan the ring window around (cx,cy), move, then one idle pixel that
    // absorbs the post-move ring wipe.
    task automatic frame(input int cx, input int cy, input int r);
        for (int v = cy - r - 1; v <= cy + r + 1; v++)
            for (int h = cx - r - 1; h <= cx + r + 1; h++)
                pix(h, v, !occupied(h, v), 1'b0, 1'b0);
        pix(0, 0, 1'b1, 1'b1, 1'b0);
        pix(0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        draw_vec_t vecs[14];
        int ex19[8] = '{319, 318, 317, 316, 315, 314, 315, 316};
        int ey19[8] = '{239, 238, 237, 236, 235, 234, 233, 232};
        int cx;
        int cy;
        int d_base;

        vecs[0]  = '{h: 320,  v: 240, exp_a: 1'b1, exp_b: 1'b1, exp_c: 1'b0};
        vecs[1]  = '{h: 317,  v: 240, exp_a: 1'b1, exp_b: 1'b0, exp_c: 1'b0};
        vecs[2]  = '{h: 316,  v: 240, exp_a: 1'b0, exp_b: 1'b0, exp_c: 1'b0};
        vecs[3]  = '{h: 323,  v: 243, exp_a: 1'b1, exp_b: 1'b0, exp_c: 1'b0};
        vecs[4]  = '{h: 324,  v: 243, exp_a: 1'b0, exp_b: 1'b0, exp_c: 1'b0};
        vecs[5]  = '{h: 321,  v: 239, exp_a: 1'b1, exp_b: 1'b1, exp_c: 1'b0};
        vecs[6]  = '{h: 322,  v: 240, exp_a: 1'b1, exp_b: 1'b0, exp_c: 1'b0};
        vecs[7]  = '{h: 319,  v: 241, exp_a: 1'b1, exp_b: 1'b1, exp_c: 1'b0};
        vecs[8]  = '{h: 320,  v: 236, exp_a: 1'b0, exp_b: 1'b0, exp_c: 1'b0};
        vecs[9]  = '{h: 320,  v: 237, exp_a: 1'b1, exp_b: 1'b0, exp_c: 1'b0};
        vecs[10] = '{h: 0,    v: 0,   exp_a: 1'b0, exp_b: 1'b0, exp_c: 1'b0};
        vecs[11] = '{h: 1023, v: 1023, exp_a: 1'b0, exp_b: 1'b0, exp_c: 1'b0};
        vecs[12] = '{h: 0,    v: 240, exp_a: 1'b0, exp_b: 1'b0, exp_c: 1'b1};
        vecs[13] = '{h: 1023, v: 240, exp_a: 1'b0, exp_b: 1'b0, exp_c: 1'b0};

        // ---------------- reset state ----------------
        do_reset();
        check("rst_a_alive",     32'(a_alive),     32'd1);
        check("rst_a_destroyed", 32'(a_destroyed), 32'd0);
        check("rst_a_xloc",      32'(a_xloc),      32'd320);
        check("rst_a_yloc",      32'(a_yloc),      32'd240);
        check("rst_b_alive",     32'(b_alive),     32'd1);
        check("rst_b_destroyed", 32'(b_destroyed), 32'd0);
        check("rst_c_alive",     32'(c_alive),     32'd1);
        check("rst_c_destroyed", 32'(c_destroyed), 32'd0);
        check("rst_c_xloc",      32'(c_xloc),      32'd2);
        check("rst_c_yloc",      32'(c_yloc),      32'd240);

        // ---------------- body footprint table ----------------
        for (int i = 0; i < 14; i++) begin
            peek(vecs[i].h, vecs[i].v);
            check($sformatf("draw_a[%0d]", i), 32'(a_draw), 32'(vecs[i].exp_a));
            check($sformatf("draw_b[%0d]", i), 32'(b_draw), 32'(vecs[i].exp_b));
            check($sformatf("draw_c[%0d]", i), 32'(c_draw), 32'(vecs[i].exp_c));
        end

        // ---------------- wall column at x=310, RADIUS=3 ----------------
        do_reset();
        wall_x = 310;
        cx = 320;
        cy = 240;
        for (int i = 0; i < 8; i++) begin
            frame(cx, cy, 3);
            check($sformatf("wall_x[%0d]", i), 32'(a_xloc), 32'(ex19[i]));
            check($sformatf("wall_y[%0d]", i), 32'(a_yloc), 32'(ey19[i]));
            cx = ex19[i];
            cy = ey19[i];
        end
        wall_x = -1;

        // ---------------- single up-left corner pixel, RADIUS=1 ----------------
        do_reset();
        obs_x = 318;
        obs_y = 238;
        frame(320, 240, 1);
        check("corner_x", 32'(b_xloc), 32'd321);
        check("corner_y", 32'(b_yloc), 32'd241);
        obs_x = -1;
        obs_y = -1;
        frame(321, 240 + 1, 1);
        check("corner_dir_x", 32'(b_xloc), 32'd322);
        check("corner_dir_y", 32'(b_yloc), 32'd242);

        // ---------------- hit with move, explode, dead, respawn ----------------
        do_reset();
        d_base = d_cycles;
        @(negedge clk);
        hcount   = 10'd0;
        vcount   = 10'd0;
        empty    = 1'b1;
        hit      = 1'b1;
        move     = 1'b1;
        pixpulse = 1'b1;
        @(negedge clk);
        pixpulse = 1'b0;
        hit      = 1'b0;
        move     = 1'b0;
        check("hit_destroyed_pulse", 32'(a_destroyed), 32'd1);
        check("hit_alive_low",       32'(a_alive),     32'd0);
        @(negedge clk);
        check("hit_destroyed_one_clk", 32'(a_destroyed), 32'd0);
        check("hit_freeze_x", 32'(a_xloc), 32'd320);
        check("hit_freeze_y", 32'(a_yloc), 32'd240);

        peek(320, 240);
        check("explode0_draw_even", 32'(a_draw), 32'd0);
        peek(321, 240);
        check("explode0_draw_odd",  32'(a_draw), 32'd1);
        do_moves(1);
        peek(320, 240);
        check("explode1_draw_even", 32'(a_draw), 32'd1);

        pix(0, 0, 1'b1, 1'b0, 1'b1);    // hit while exploding
        do_moves(6);
        peek(320, 240);
        check("explode7_draw", 32'(a_draw), 32'd1);
        check("explode7_x",    32'(a_xloc), 32'd320);
        check("explode7_alive", 32'(a_alive), 32'd0);

        do_moves(1);
        peek(320, 240);
        check("dead_draw_even", 32'(a_draw), 32'd0);
        peek(321, 240);
        check("dead_draw_odd",  32'(a_draw), 32'd0);
        check("dead_alive",     32'(a_alive), 32'd0);

        pix(0, 0, 1'b1, 1'b1, 1'b1);    // hit with move while dead: move 1 of 64
        do_moves(62);
        check("dead63_alive", 32'(a_alive), 32'd0);
        do_moves(1);
        check("respawn_alive", 32'(a_alive), 32'd1);
        check("respawn_x",     32'(a_xloc),  32'd320);
        check("respawn_y",     32'(a_yloc),  32'd240);
        check("destroyed_cycles", 32'(d_cycles - d_base), 32'd1);
        pix(0, 0, 1'b1, 1'b1, 1'b0);
        pix(0, 0, 1'b1, 1'b0, 1'b0);
        check("respawn_dir_x", 32'(a_xloc), 32'd321);
        check("respawn_dir_y", 32'(a_yloc), 32'd241);

        // ---------------- reset in the middle of an explosion ----------------
        do_reset();
        do_moves(2);
        check("pre_hit_x", 32'(a_xloc), 32'd318);
        check("pre_hit_y", 32'(a_yloc), 32'd238);
        pix(0, 0, 1'b1, 1'b0, 1'b1);
        do_moves(1);
        check("mid_explode_alive", 32'(a_alive), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_alive",     32'(a_alive),     32'd1);
        check("async_rst_x",         32'(a_xloc),      32'd320);
        check("async_rst_y",         32'(a_yloc),      32'd240);
        check("async_rst_destroyed", 32'(a_destroyed), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- left screen edge, xloc=2, RADIUS=3 ----------------
        do_reset();
        for (int v = 237; v <= 243; v++) begin
            for (int h = 0; h <= 9; h++)
                if (h != 6) pix(h, v, 1'b0, 1'b0, 1'b0);
            pix(1022, v, 1'b0, 1'b0, 1'b0);
        end
        pix(0, 0, 1'b1, 1'b1, 1'b0);
        check("edge_no_wrap_x", 32'(c_xloc), 32'd1);
        check("edge_no_wrap_y", 32'(c_yloc), 32'd239);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
